// File: rtl/pll_lock_sequencer_if.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer_if
//
// Purpose:
//   Groups the PLL-facing and status signals of pll_lock_sequencer so the
//   sequencer and its surroundings connect through one bundle.
//   Clock (clkin) and reset stay plain module ports.
//
// Signals:
//   pll_lock       PLL LOCK, asynchronous to clkin         (peer -> sequencer)
//   relock_req     single-cycle re-sequence request        (peer -> sequencer)
//   pll_reset      PLL reset, active-high                  (sequencer -> peer)
//   rst_out        downstream core reset, active-high      (sequencer -> peer)
//   locked         high only in RUN                        (sequencer -> peer)
//   fail           high only in FAIL                       (sequencer -> peer)
//   retry_cnt[3:0] failed attempts in current sequence     (sequencer -> peer)
//   state_o[2:0]   debug view of the FSM state             (sequencer -> peer)
//   lock_loss_cnt[7:0]  saturating count of lock losses in RUN
//                       (present only when PLL_LOSS_COUNTER_EN is defined)
//
// Modports:
//   master  the sequencer side
//   slave   the side that owns the PLL LOCK pin and the register file
// ---------------------------------------------------------------------------
interface pll_lock_sequencer_if;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_reset;
    logic       rst_out;
    logic       locked;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [2:0] state_o;
`ifdef PLL_LOSS_COUNTER_EN
    logic [7:0] lock_loss_cnt;
`endif

`ifdef PLL_LOSS_COUNTER_EN
    modport master (
        input  pll_lock,
        input  relock_req,
        output pll_reset,
        output rst_out,
        output locked,
        output fail,
        output retry_cnt,
        output state_o,
        output lock_loss_cnt
    );

    modport slave (
        output pll_lock,
        output relock_req,
        input  pll_reset,
        input  rst_out,
        input  locked,
        input  fail,
        input  retry_cnt,
        input  state_o,
        input  lock_loss_cnt
    );
`else
    modport master (
        input  pll_lock,
        input  relock_req,
        output pll_reset,
        output rst_out,
        output locked,
        output fail,
        output retry_cnt,
        output state_o
    );

    modport slave (
        output pll_lock,
        output relock_req,
        input  pll_reset,
        input  rst_out,
        input  locked,
        input  fail,
        input  retry_cnt,
        input  state_o
    );
`endif
endinterface

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//
// Purpose:
//   Brings up the rPLL that produces the I2C/PWM core clock. The PLL is held
//   in reset for RST_HOLD_CYCLES, then LOCK is awaited with a per-attempt
//   timeout. LOCK must stay high for LOCK_STABLE_CYCLES consecutive cycles
//   before the downstream core reset is released. A failed attempt retries
//   until MAX_RETRIES attempts have failed, after which the PLL is parked in
//   reset (FAIL) until a re-lock request. Loss of lock while running, or a
//   software re-lock request, restarts the whole sequence.
//   Everything runs on the PLL reference clock, since the PLL output is not
//   usable until lock.
//
// Ports:
//   clkin   in   reference clock (also the PLL input clock)
//   reset   in   synchronous, active-high block reset
//   bus     pll_lock_sequencer_if.master
//             pll_lock, relock_req in; pll_reset, rst_out, locked, fail,
//             retry_cnt[3:0], state_o[2:0] out (all outputs registered)
//
// Optional feature (macro PLL_LOSS_COUNTER_EN):
//   Adds bus.lock_loss_cnt[7:0], a saturating count of RUN->RESET
//   transitions caused by loss of lock. Cleared only by reset.
//
// State encoding on state_o: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 27000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                    clkin,
    input  logic                    reset,
    pll_lock_sequencer_if.master    bus
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    // Each counter only has to reach (parameter - 1) before it is cleared.
    localparam int HOLD_W   = $clog2(RST_HOLD_CYCLES);
    localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES);
    localparam int TIMER_W  = $clog2(LOCK_TIMEOUT_CYCLES);

    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]          RETRY_LIMIT = 4'(MAX_RETRIES);

    localparam logic [HOLD_W-1:0]   HOLD_ONE    = HOLD_W'(1);
    localparam logic [STABLE_W-1:0] STABLE_ONE  = STABLE_W'(1);
    localparam logic [TIMER_W-1:0]  TIMER_ONE   = TIMER_W'(1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e              state_q,      state_d;
    logic [HOLD_W-1:0]   hold_cnt_q,   hold_cnt_d;
    logic [STABLE_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [TIMER_W-1:0]  timer_q,      timer_d;
    logic [3:0]          retry_cnt_q,  retry_cnt_d;
`ifdef PLL_LOSS_COUNTER_EN
    logic [7:0]          loss_cnt_q,   loss_cnt_d;
`endif

    logic [1:0]          sync_q;
    logic                pll_reset_q;
    logic                rst_out_q;
    logic                locked_q;
    logic                fail_q;

    logic                lock_s;
    logic                timeout;
    logic [3:0]          retry_inc;
    state_e              timeout_state;

    // pll_lock comes from another clock domain; only the second flop is used.
    assign lock_s        = sync_q[1];
    assign timeout       = (timer_q == TIMER_LAST);
    assign retry_inc     = retry_cnt_q + 4'd1;
    assign timeout_state = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RESET;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        stable_cnt_d = stable_cnt_q;
        timer_d      = timer_q;
        retry_cnt_d  = retry_cnt_q;
`ifdef PLL_LOSS_COUNTER_EN
        loss_cnt_d   = loss_cnt_q;
`endif

        if (bus.relock_req) begin
            // Software re-lock beats every normal transition, including a
            // pending RUN entry; re-entering RESET restarts the hold count.
            state_d      = ST_RESET;
            hold_cnt_d   = '0;
            stable_cnt_d = '0;
            timer_d      = '0;
            retry_cnt_d  = '0;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = ST_WAIT_LOCK;
                        hold_cnt_d = '0;
                        timer_d    = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_ONE;
                    end
                end

                ST_WAIT_LOCK: begin
                    timer_d      = timer_q + TIMER_ONE;
                    stable_cnt_d = '0;
                    if (timeout) begin
                        state_d     = timeout_state;
                        retry_cnt_d = retry_inc;
                        timer_d     = '0;
                        hold_cnt_d  = '0;
                    end else if (lock_s) begin
                        state_d = ST_STABLE;
                    end
                end

                ST_STABLE: begin
                    // The timeout timer spans WAIT_LOCK and STABLE together,
                    // so dropping back to WAIT_LOCK does not restart it.
                    timer_d = timer_q + TIMER_ONE;
                    if (lock_s && (stable_cnt_q == STABLE_LAST)) begin
                        // RUN entry wins over a coincident timeout.
                        state_d      = ST_RUN;
                        retry_cnt_d  = '0;
                        stable_cnt_d = '0;
                        timer_d      = '0;
                    end else if (timeout) begin
                        state_d      = timeout_state;
                        retry_cnt_d  = retry_inc;
                        timer_d      = '0;
                        stable_cnt_d = '0;
                        hold_cnt_d   = '0;
                    end else if (lock_s) begin
                        stable_cnt_d = stable_cnt_q + STABLE_ONE;
                    end else begin
                        state_d      = ST_WAIT_LOCK;
                        stable_cnt_d = '0;
                    end
                end

                ST_RUN: begin
                    if (!lock_s) begin
                        state_d    = ST_RESET;
                        hold_cnt_d = '0;
`ifdef PLL_LOSS_COUNTER_EN
                        if (loss_cnt_q != 8'hFF) begin
                            loss_cnt_d = loss_cnt_q + 8'd1;
                        end
`endif
                    end
                end

                ST_FAIL: begin
                    // Parked: only relock_req or reset leave this state.
                end

                default: begin
                    state_d      = ST_RESET;
                    hold_cnt_d   = '0;
                    stable_cnt_d = '0;
                    timer_d      = '0;
                    retry_cnt_d  = '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Registers. Outputs are decoded from the next state so they change on
    // the same edge as state_q.
    // ---------------------------------------------------------------------
    always_ff @(posedge clkin) begin
        // NOTE: non-blocking assignments only, so every flop samples the
        // values from before this edge regardless of statement order.
        if (reset) begin
            state_q      <= ST_RESET;
            hold_cnt_q   <= '0;
            stable_cnt_q <= '0;
            timer_q      <= '0;
            retry_cnt_q  <= '0;
            sync_q       <= '0;
            pll_reset_q  <= 1'b1;
            rst_out_q    <= 1'b1;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
`ifdef PLL_LOSS_COUNTER_EN
            loss_cnt_q   <= '0;
`endif
        end else begin
            sync_q       <= {sync_q[0], bus.pll_lock};
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            timer_q      <= timer_d;
            retry_cnt_q  <= retry_cnt_d;
            pll_reset_q  <= (state_d == ST_RESET) || (state_d == ST_FAIL);
            rst_out_q    <= (state_d != ST_RUN);
            locked_q     <= (state_d == ST_RUN);
            fail_q       <= (state_d == ST_FAIL);
`ifdef PLL_LOSS_COUNTER_EN
            loss_cnt_q   <= loss_cnt_d;
`endif
        end
    end

    assign bus.pll_reset = pll_reset_q;
    assign bus.rst_out   = rst_out_q;
    assign bus.locked    = locked_q;
    assign bus.fail      = fail_q;
    assign bus.retry_cnt = retry_cnt_q;
    assign bus.state_o   = state_q;
`ifdef PLL_LOSS_COUNTER_EN
    assign bus.lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Bench for pll_lock_sequencer with RST_HOLD_CYCLES=4, LOCK_STABLE_CYCLES=8,
// LOCK_TIMEOUT_CYCLES=50, MAX_RETRIES=2.
//
// Each scenario starts from a one-edge reset (edge 0), then numbers the
// following rising edges 1, 2, ... Inputs are changed on the falling edge
// before the rising edge that samples them; outputs are read on the falling
// edge after a rising edge. Expected output snapshots, derived from the
// sequencing timeline, are queued per edge before the scenario runs and
// popped when that edge's outputs are observed.
// ---------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STABLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;

    typedef struct {
        int          cyc;
        string       name;
        logic [10:0] v;
    } exp_t;

    logic clkin = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    pll_lock_sequencer_if bus();

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES     (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (50),
        .MAX_RETRIES         (2)
    ) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    // Observed outputs: {pll_reset, rst_out, locked, fail, retry_cnt, state}
    function automatic logic [10:0] snap();
        return {bus.pll_reset, bus.rst_out, bus.locked, bus.fail,
                bus.retry_cnt, bus.state_o};
    endfunction

    // Expected snapshot for a state and retry count.
    function automatic logic [10:0] mk(input logic [2:0] st, input logic [3:0] r);
        logic [3:0] f;
        case (st)
            S_RESET:         f = 4'b1100;
            S_WAIT, S_STABLE: f = 4'b0100;
            S_RUN:           f = 4'b0010;
            default:         f = 4'b1101;
        endcase
        return {f, r, st};
    endfunction

    task automatic expect_span(input string nm, input int a, input int b,
                               input logic [2:0] st, input logic [3:0] r);
        for (int i = a; i <= b; i++) begin
            sb.push_back('{i, nm, mk(st, r)});
        end
    endtask

    task automatic do_reset();
        @(negedge clkin);
        reset          = 1'b1;
        bus.pll_lock   = 1'b0;
        bus.relock_req = 1'b0;
        @(negedge clkin);
        reset = 1'b0;
    endtask

    // Reset held for edges 1..3 keeps the hold count at 0; pll_reset then
    // stays high for exactly 4 cycles after release.
    task automatic test_reset();
        exp_t e;
        do_reset();
        reset = 1'b1;
        expect_span("reset_hold", 1, 6, S_RESET, 4'd0);
        expect_span("reset_wait", 7, 8, S_WAIT,  4'd0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clkin);
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                total++;
                if (snap() !== e.v) begin
                    bad++;
                    $display("FAIL %s edge=%0d got=%h want=%h", e.name, c, snap(), e.v);
                end
            end
            reset = (c + 1 <= 3);
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL reset_leftover got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    // Lock sampled high from edge 15 -> RUN after edge 25; lock dropped at
    // edge 30 -> RESET after edge 32; relock at 37 restarts the sequence.
    task automatic test_lock_release();
        exp_t e;
        do_reset();
        expect_span("rel_rst",    1,  3,  S_RESET,  4'd0);
        expect_span("rel_wait",   4,  16, S_WAIT,   4'd0);
        expect_span("rel_stable", 17, 24, S_STABLE, 4'd0);
        expect_span("rel_run",    25, 31, S_RUN,    4'd0);
        expect_span("loss_rst",   32, 35, S_RESET,  4'd0);
        expect_span("loss_wait",  36, 36, S_WAIT,   4'd0);
        expect_span("relk_rst",   37, 40, S_RESET,  4'd0);
        expect_span("relk_wait",  41, 42, S_WAIT,   4'd0);
        for (int c = 1; c <= 42; c++) begin
            @(negedge clkin);
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                total++;
                if (snap() !== e.v) begin
                    bad++;
                    $display("FAIL %s edge=%0d got=%h want=%h", e.name, c, snap(), e.v);
                end
            end
`ifdef PLL_LOSS_COUNTER_EN
            if (c == 31 || c == 33 || c == 42) begin
                total++;
                if (bus.lock_loss_cnt !== ((c == 31) ? 8'd0 : 8'd1)) begin
                    bad++;
                    $display("FAIL loss_cnt edge=%0d got=%0d want=%0d",
                             c, bus.lock_loss_cnt, (c == 31) ? 0 : 1);
                end
            end
`endif
            bus.pll_lock   = (c + 1 >= 15) && (c + 1 <= 29);
            bus.relock_req = (c + 1 == 37);
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL rel_leftover got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    // No lock: two 4-cycle resets and 50-cycle waits, then FAIL; relock
    // at edge 116 returns to RESET with everything cleared.
    task automatic test_no_lock_fail();
        exp_t e;
        do_reset();
        expect_span("nl_rst0",  1,   3,   S_RESET, 4'd0);
        expect_span("nl_wait0", 4,   53,  S_WAIT,  4'd0);
        expect_span("nl_rst1",  54,  57,  S_RESET, 4'd1);
        expect_span("nl_wait1", 58,  107, S_WAIT,  4'd1);
        expect_span("nl_fail",  108, 115, S_FAIL,  4'd2);
        expect_span("nl_relk",  116, 119, S_RESET, 4'd0);
        expect_span("nl_wait2", 120, 121, S_WAIT,  4'd0);
        for (int c = 1; c <= 121; c++) begin
            @(negedge clkin);
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                total++;
                if (snap() !== e.v) begin
                    bad++;
                    $display("FAIL %s edge=%0d got=%h want=%h", e.name, c, snap(), e.v);
                end
            end
            bus.relock_req = (c + 1 == 116);
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL nl_leftover got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    // Lock high for edges 15..19, low 20..21, high from 22: STABLE falls back
    // to WAIT_LOCK and RUN follows 10 edges after the second rise.
    task automatic test_glitch();
        exp_t e;
        do_reset();
        expect_span("gl_rst",     1,  3,  S_RESET,  4'd0);
        expect_span("gl_wait",    4,  16, S_WAIT,   4'd0);
        expect_span("gl_stable1", 17, 21, S_STABLE, 4'd0);
        expect_span("gl_wait2",   22, 23, S_WAIT,   4'd0);
        expect_span("gl_stable2", 24, 31, S_STABLE, 4'd0);
        expect_span("gl_run",     32, 34, S_RUN,    4'd0);
        for (int c = 1; c <= 34; c++) begin
            @(negedge clkin);
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                total++;
                if (snap() !== e.v) begin
                    bad++;
                    $display("FAIL %s edge=%0d got=%h want=%h", e.name, c, snap(), e.v);
                end
            end
            bus.pll_lock = ((c + 1 >= 15) && (c + 1 <= 19)) || (c + 1 >= 22);
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL gl_leftover got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    // Same glitch but the second rise comes late (edge 45, timer 41): the
    // timer kept running, so edge 54 times out in STABLE; the retry locks.
    task automatic test_glitch_timeout();
        exp_t e;
        do_reset();
        expect_span("gt_rst",     1,  3,  S_RESET,  4'd0);
        expect_span("gt_wait",    4,  16, S_WAIT,   4'd0);
        expect_span("gt_stable1", 17, 21, S_STABLE, 4'd0);
        expect_span("gt_wait2",   22, 46, S_WAIT,   4'd0);
        expect_span("gt_stable2", 47, 53, S_STABLE, 4'd0);
        expect_span("gt_retry",   54, 57, S_RESET,  4'd1);
        expect_span("gt_wait3",   58, 58, S_WAIT,   4'd1);
        expect_span("gt_stable3", 59, 66, S_STABLE, 4'd1);
        expect_span("gt_run",     67, 68, S_RUN,    4'd0);
        for (int c = 1; c <= 68; c++) begin
            @(negedge clkin);
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                total++;
                if (snap() !== e.v) begin
                    bad++;
                    $display("FAIL %s edge=%0d got=%h want=%h", e.name, c, snap(), e.v);
                end
            end
            bus.pll_lock = ((c + 1 >= 15) && (c + 1 <= 19)) || (c + 1 >= 45);
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL gt_leftover got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    // Lock sampled from edge 44: RUN entry lands on edge 54, the same edge
    // as timer==49. RUN must win with no retry.
    task automatic test_timeout_vs_run();
        exp_t e;
        do_reset();
        expect_span("tr_rst",    1,  3,  S_RESET,  4'd0);
        expect_span("tr_wait",   4,  45, S_WAIT,   4'd0);
        expect_span("tr_stable", 46, 53, S_STABLE, 4'd0);
        expect_span("tr_run",    54, 56, S_RUN,    4'd0);
        for (int c = 1; c <= 56; c++) begin
            @(negedge clkin);
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                total++;
                if (snap() !== e.v) begin
                    bad++;
                    $display("FAIL %s edge=%0d got=%h want=%h", e.name, c, snap(), e.v);
                end
            end
            bus.pll_lock = (c + 1 >= 44);
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL tr_leftover got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    // relock at edge 2 (in RESET) restarts the hold count; relock at edge 25
    // coincides with RUN entry and RESET must win.
    task automatic test_relock();
        exp_t e;
        do_reset();
        bus.relock_req = 1'b0;
        expect_span("rk_rst",     1,  5,  S_RESET,  4'd0);
        expect_span("rk_wait",    6,  16, S_WAIT,   4'd0);
        expect_span("rk_stable",  17, 24, S_STABLE, 4'd0);
        expect_span("rk_rst2",    25, 28, S_RESET,  4'd0);
        expect_span("rk_wait2",   29, 29, S_WAIT,   4'd0);
        expect_span("rk_stable2", 30, 37, S_STABLE, 4'd0);
        expect_span("rk_run",     38, 39, S_RUN,    4'd0);
        for (int c = 1; c <= 39; c++) begin
            @(negedge clkin);
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                total++;
                if (snap() !== e.v) begin
                    bad++;
                    $display("FAIL %s edge=%0d got=%h want=%h", e.name, c, snap(), e.v);
                end
            end
            bus.pll_lock   = (c + 1 >= 15);
            bus.relock_req = (c + 1 == 2) || (c + 1 == 25);
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL rk_leftover got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    // Block reset at edge 21 (mid-STABLE) returns every output to its reset
    // value on that edge; the synchronizer refills before the next STABLE.
    task automatic test_reset_mid_stable();
        exp_t e;
        do_reset();
        expect_span("rm_rst",     1,  3,  S_RESET,  4'd0);
        expect_span("rm_wait",    4,  16, S_WAIT,   4'd0);
        expect_span("rm_stable",  17, 20, S_STABLE, 4'd0);
        expect_span("rm_reset",   21, 24, S_RESET,  4'd0);
        expect_span("rm_wait2",   25, 25, S_WAIT,   4'd0);
        expect_span("rm_stable2", 26, 27, S_STABLE, 4'd0);
        for (int c = 1; c <= 27; c++) begin
            @(negedge clkin);
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                total++;
                if (snap() !== e.v) begin
                    bad++;
                    $display("FAIL %s edge=%0d got=%h want=%h", e.name, c, snap(), e.v);
                end
            end
            bus.pll_lock = (c + 1 >= 15);
            reset        = (c + 1 == 21);
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL rm_leftover got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        bus.pll_lock   = 1'b0;
        bus.relock_req = 1'b0;
        test_reset();
        test_lock_release();
        test_no_lock_fail();
        test_glitch();
        test_glitch_timeout();
        test_timeout_vs_run();
        test_relock();
        test_reset_mid_stable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog elapsed=%0t total=%0d", $time, total);
        $fatal(1);
    end

endmodule
